// File: rtl/matrix_scanner.sv
// Front-panel LED/switch matrix scanner sharing one column bus, with per-bit frame debounce.
// Define MATRIX_SCANNER_EDGE_EN to build the sw_rise/sw_fall pulse outputs.
module matrix_scanner #(
    parameter int COLS        = 12,
    parameter int LED_ROWS    = 8,
    parameter int SW_ROWS     = 3,
    parameter int TICK_DIV    = 5000,
    parameter int ON_TICKS    = 32,
    parameter int BLANK_TICKS = 2,
    parameter int SW_TICKS    = 1,
    parameter int DB_SAMPLES  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LED_ROWS*COLS-1:0]  led_data,
    output logic [COLS-1:0]           col_o,
    output logic                      col_oe,
    input  logic [COLS-1:0]           col_i,
    output logic [LED_ROWS-1:0]       led_row_o,
    output logic                      led_row_oe,
    output logic [SW_ROWS-1:0]        sw_row_o,
    output logic [SW_ROWS*COLS-1:0]   sw_state,
    output logic [SW_ROWS*COLS-1:0]   sw_rise,
    output logic [SW_ROWS*COLS-1:0]   sw_fall,
    output logic                      frame_done
);
    localparam int NBITS  = SW_ROWS * COLS;
    localparam int MAX_A  = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
    localparam int MAX_T  = (MAX_A > SW_TICKS) ? MAX_A : SW_TICKS;
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int SLOT_W = $clog2(MAX_T + 1);
    localparam int ROW_W  = 4;

    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
    localparam logic [SLOT_W-1:0] ON_LAST     = SLOT_W'(ON_TICKS - 1);
    localparam logic [SLOT_W-1:0] BLANK_LAST  = SLOT_W'(BLANK_TICKS - 1);
    localparam logic [SLOT_W-1:0] SW_LAST     = SLOT_W'(SW_TICKS - 1);
    localparam logic [ROW_W-1:0]  LED_ROW_END = ROW_W'(LED_ROWS - 1);
    localparam logic [ROW_W-1:0]  SW_ROW_END  = ROW_W'(SW_ROWS - 1);
    localparam logic [3:0]        DB_LIMIT    = 4'(DB_SAMPLES);

    typedef enum logic [1:0] {LED_ON, LED_BLANK, SW_STROBE, SW_GAP} state_t;

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_q;
    logic [SLOT_W-1:0]   slot_q, slot_d, slot_last;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [COLS-1:0]     sync1_q, sync2_q;
    logic [NBITS-1:0]    sample_q, sample_d;
    logic [NBITS-1:0]    sw_state_q, sw_state_d;
    logic [3:0]          db_cnt_q [NBITS];
    logic [3:0]          db_cnt_d [NBITS];
    logic                tick, frame_end;

    logic [COLS-1:0]     col_q, col_d;
    logic                col_oe_q, col_oe_d;
    logic [LED_ROWS-1:0] led_row_q, led_row_d;
    logic                led_oe_q, led_oe_d;
    logic [SW_ROWS-1:0]  sw_row_q, sw_row_d;
    logic                frame_done_q;

    always_comb begin
        tick      = (tick_q == TICK_LAST);
        slot_last = ON_LAST;
        case (state_q)
            LED_ON:    slot_last = ON_LAST;
            LED_BLANK: slot_last = BLANK_LAST;
            SW_STROBE: slot_last = SW_LAST;
            SW_GAP:    slot_last = BLANK_LAST;
            default:   slot_last = ON_LAST;
        endcase

        state_d   = state_q;
        slot_d    = slot_q;
        row_d     = row_q;
        sample_d  = sample_q;
        frame_end = 1'b0;
        if (tick) begin
            if (slot_q == slot_last) begin
                slot_d = '0;
                case (state_q)
                    LED_ON: state_d = LED_BLANK;
                    LED_BLANK: begin
                        if (row_q == LED_ROW_END) begin
                            state_d = SW_STROBE;
                            row_d   = '0;
                        end else begin
                            state_d = LED_ON;
                            row_d   = row_q + ROW_W'(1);
                        end
                    end
                    SW_STROBE: begin
                        sample_d[int'(row_q)*COLS +: COLS] = ~sync2_q;
                        if (row_q == SW_ROW_END) begin
                            state_d = SW_GAP;
                            row_d   = '0;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end
                    SW_GAP: begin
                        state_d   = LED_ON;
                        row_d     = '0;
                        frame_end = 1'b1;
                    end
                    default: state_d = LED_ON;
                endcase
            end else begin
                slot_d = slot_q + SLOT_W'(1);
            end
        end
    end

    // Debounce runs once per frame on the samples gathered during that frame's strobes.
    always_comb begin
        for (int unsigned i = 0; i < NBITS; i++) begin
            sw_state_d[i] = sw_state_q[i];
            db_cnt_d[i]   = db_cnt_q[i];
            if (frame_end) begin
                if (sample_q[i] == sw_state_q[i]) begin
                    db_cnt_d[i] = '0;
                end else if (db_cnt_q[i] + 4'd1 == DB_LIMIT) begin
                    sw_state_d[i] = ~sw_state_q[i];
                    db_cnt_d[i]   = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 4'd1;
                end
            end
        end
    end

    // Pad outputs decode the next state so they switch on the same edge as the state register.
    always_comb begin
        col_d     = '1;
        col_oe_d  = 1'b0;
        led_row_d = '0;
        led_oe_d  = 1'b0;
        sw_row_d  = '1;
        case (state_d)
            LED_ON: begin
                col_oe_d  = 1'b1;
                col_d     = ~led_data[int'(row_d)*COLS +: COLS];
                led_oe_d  = 1'b1;
                led_row_d = LED_ROWS'(1) << row_d;
            end
            SW_STROBE: sw_row_d = ~(SW_ROWS'(1) << row_d);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q       <= '0;
            state_q      <= LED_ON;
            slot_q       <= '0;
            row_q        <= '0;
            sync1_q      <= '1;
            sync2_q      <= '1;
            sample_q     <= '0;
            sw_state_q   <= '0;
            db_cnt_q     <= '{default: '0};
            col_q        <= '1;
            col_oe_q     <= 1'b0;
            led_row_q    <= '0;
            led_oe_q     <= 1'b0;
            sw_row_q     <= '1;
            frame_done_q <= 1'b0;
        end else begin
            tick_q       <= tick ? '0 : tick_q + TICK_W'(1);
            state_q      <= state_d;
            slot_q       <= slot_d;
            row_q        <= row_d;
            sync1_q      <= col_i;
            sync2_q      <= sync1_q;
            sample_q     <= sample_d;
            sw_state_q   <= sw_state_d;
            db_cnt_q     <= db_cnt_d;
            col_q        <= col_d;
            col_oe_q     <= col_oe_d;
            led_row_q    <= led_row_d;
            led_oe_q     <= led_oe_d;
            sw_row_q     <= sw_row_d;
            frame_done_q <= frame_end;
        end
    end

`ifdef MATRIX_SCANNER_EDGE_EN
    logic [NBITS-1:0] rise_q, fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= sw_state_d & ~sw_state_q;
            fall_q <= ~sw_state_d & sw_state_q;
        end
    end

    assign sw_rise = rise_q;
    assign sw_fall = fall_q;
`else
    assign sw_rise = '0;
    assign sw_fall = '0;
`endif

    assign col_o      = col_q;
    assign col_oe     = col_oe_q;
    assign led_row_o  = led_row_q;
    assign led_row_oe = led_oe_q;
    assign sw_row_o   = sw_row_q;
    assign sw_state   = sw_state_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_matrix_scanner.sv
// Self-checking bench for matrix_scanner: emulates a switch matrix on the column bus and
// predicts every output from frame-position arithmetic and a per-bit run-length debounce model.
module tb_matrix_scanner;
    localparam int COLS     = 4;
    localparam int LED_ROWS = 2;
    localparam int SW_ROWS  = 2;
    localparam int TD       = 4;
    localparam int ON       = 2;
    localparam int BL       = 1;
    localparam int SW       = 1;
    localparam int DB       = 2;
    localparam int NB       = SW_ROWS * COLS;
    localparam int LED_SPAN = LED_ROWS * (ON + BL);
    localparam int FRAME    = LED_SPAN + SW_ROWS * SW + BL;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [LED_ROWS*COLS-1:0] led_data;
    logic [COLS-1:0]          col_o;
    logic                     col_oe;
    logic [COLS-1:0]          col_i;
    logic [LED_ROWS-1:0]      led_row_o;
    logic                     led_row_oe;
    logic [SW_ROWS-1:0]       sw_row_o;
    logic [NB-1:0]            sw_state, sw_rise, sw_fall;
    logic                     frame_done;

    logic [NB-1:0] sw_phys;
    int            n_checks = 0;
    int            n_errors = 0;

    // Model state
    int            n;
    logic [NB-1:0] m_state;
    int            m_run [NB];
    logic          m_fd, m_lit;
    int            m_row;
    logic [COLS-1:0]     e_col;
    logic [LED_ROWS-1:0] e_led_row;
    logic [SW_ROWS-1:0]  e_sw_row;
    logic [NB-1:0]       e_rise, e_fall;

    matrix_scanner #(
        .COLS(COLS), .LED_ROWS(LED_ROWS), .SW_ROWS(SW_ROWS), .TICK_DIV(TD),
        .ON_TICKS(ON), .BLANK_TICKS(BL), .SW_TICKS(SW), .DB_SAMPLES(DB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .led_data(led_data),
        .col_o(col_o), .col_oe(col_oe), .col_i(col_i),
        .led_row_o(led_row_o), .led_row_oe(led_row_oe), .sw_row_o(sw_row_o),
        .sw_state(sw_state), .sw_rise(sw_rise), .sw_fall(sw_fall),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Pulled-up column bus: a closed switch on a strobed (low) row pulls its column low.
    always_comb begin
        col_i = '1;
        for (int r = 0; r < SW_ROWS; r++)
            if (!sw_row_o[r]) col_i = col_i & ~sw_phys[r*COLS +: COLS];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        n       = 0;
        m_state = '0;
        for (int i = 0; i < NB; i++) m_run[i] = 0;
        m_fd = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_col_o"},      32'(col_o),      32'hF);
        check_eq({tag, "_col_oe"},     32'(col_oe),     32'h0);
        check_eq({tag, "_led_row_o"},  32'(led_row_o),  32'h0);
        check_eq({tag, "_led_row_oe"}, 32'(led_row_oe), 32'h0);
        check_eq({tag, "_sw_row_o"},   32'(sw_row_o),   32'h3);
        check_eq({tag, "_sw_state"},   32'(sw_state),   32'h0);
        check_eq({tag, "_sw_rise"},    32'(sw_rise),    32'h0);
        check_eq({tag, "_sw_fall"},    32'(sw_fall),    32'h0);
        check_eq({tag, "_frame_done"}, 32'(frame_done), 32'h0);
    endtask

    // One clock: predict outputs after the posedge from the tick position in the frame, check at negedge.
    task automatic step();
        int t, p, s;
        logic [NB-1:0] old;
        @(posedge clk);
        n++;
        t         = n / TD;
        p         = t % FRAME;
        m_fd      = (n % TD == 0) && (p == 0);
        m_lit     = 1'b0;
        m_row     = 0;
        e_col     = '1;
        e_led_row = '0;
        e_sw_row  = '1;
        if (p < LED_SPAN) begin
            m_row = p / (ON + BL);
            m_lit = (p % (ON + BL)) < ON;
        end else begin
            s = p - LED_SPAN;
            if (s < SW_ROWS * SW) e_sw_row[s / SW] = 1'b0;
        end
        if (m_lit) begin
            e_col            = ~led_data[m_row*COLS +: COLS];
            e_led_row[m_row] = 1'b1;
        end
        old = m_state;
        if (m_fd) begin
            for (int i = 0; i < NB; i++) begin
                if (sw_phys[i] != m_state[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_state[i] = sw_phys[i];
                        m_run[i]   = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
`ifdef MATRIX_SCANNER_EDGE_EN
        e_rise = m_state & ~old;
        e_fall = ~m_state & old;
`else
        e_rise = '0;
        e_fall = '0;
`endif
        @(negedge clk);
        check_eq("col_oe",     32'(col_oe),     32'(m_lit));
        check_eq("col_o",      32'(col_o),      32'(e_col));
        check_eq("led_row_oe", 32'(led_row_oe), 32'(m_lit));
        check_eq("led_row_o",  32'(led_row_o),  32'(e_led_row));
        check_eq("sw_row_o",   32'(sw_row_o),   32'(e_sw_row));
        check_eq("frame_done", 32'(frame_done), 32'(m_fd));
        check_eq("sw_state",   32'(sw_state),   32'(m_state));
        check_eq("sw_rise",    32'(sw_rise),    32'(e_rise));
        check_eq("sw_fall",    32'(sw_fall),    32'(e_fall));
    endtask

    // Switch image for frame f: press, release, bounce, random, then all closed.
    function automatic logic [NB-1:0] pattern(input int f);
        if (f <= 2)  return 8'h01;
        if (f <= 4)  return 8'h00;
        if (f <= 8)  return (f % 2 == 1) ? 8'h10 : 8'h00;
        if (f <= 13) return 8'($urandom);
        return 8'hFF;
    endfunction

    initial begin
        int frame;
        rst_n    = 1'b0;
        led_data = 8'hA5;
        sw_phys  = pattern(0);
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check_reset("rst");
        end
        rst_n = 1'b1;

        frame = 0;
        while (frame < 16) begin
            step();
            if (m_fd) begin
                frame++;
                sw_phys = pattern(frame);
            end
            if (frame >= 1) led_data = 8'($urandom);
        end

        // Assert reset while row 1 is lit.
        for (int k = 0; k < 4 * FRAME * TD && !(m_lit && m_row == 1); k++) begin
            step();
            led_data = 8'($urandom);
        end
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        @(negedge clk);
        check_reset("midrst_hold");
        rst_n   = 1'b1;
        model_reset();
        sw_phys = 8'($urandom);

        frame = 0;
        while (frame < 4) begin
            step();
            if (m_fd) begin
                frame++;
                sw_phys = (frame % 2 == 0) ? 8'($urandom) : sw_phys;
            end
            led_data = 8'($urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/matrix_scanner.md
# matrix_scanner

Parametrised front-panel matrix scanner for the PDP-8 family panels. It time-multiplexes an LED array and a switch array over one shared column bus with per-row strobes. It returns debounced switch levels and, optionally, one-cycle press/release pulses. It sits between the CPU's panel-signal bundle and the board pins, and replaces fixed-geometry panel scanning for any panel with up to 32 columns.

## Interface
Parameters:
- COLS, 12: column bus width (1-32)
- LED_ROWS, 8: LED rows driven (1-16)
- SW_ROWS, 3: switch rows read (1-8)
- TICK_DIV, 5000: clk cycles per scan tick (≥2)
- ON_TICKS, 32: ticks each LED row is lit (≥1)
- BLANK_TICKS, 2: ticks of blanking after each LED row and after the switch phase (≥1)
- SW_TICKS, 1: ticks each switch row is strobed (≥1)
- DB_SAMPLES, 4: consecutive differing frames needed to change a debounced bit (1-15)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- led_data  in  LED_ROWS*COLS  LED image; row r is led_data[r*COLS +: COLS], 1 = lit
- col_o  out  COLS  column drive, active-low (0 = sink = LED on)
- col_oe  out  1  column output enable
- col_i  in  COLS  column pin readback (asynchronous)
- led_row_o  out  LED_ROWS  one-hot LED row source
- led_row_oe  out  1  LED row output enable
- sw_row_o  out  SW_ROWS  switch row strobe, active-low; inactive rows are 1
- sw_state  out  SW_ROWS*COLS  debounced switch levels, 1 = closed; same packing as led_data
- sw_rise  out  SW_ROWS*COLS  one-cycle pulse on debounced 0→1
- sw_fall  out  SW_ROWS*COLS  one-cycle pulse on debounced 1→0
- frame_done  out  1  one-cycle pulse at end of each full scan frame

Clock and reset are decided: one clock; reset is asynchronous and active-low.

## Operation
- A free-running tick counter counts 0..TICK_DIV-1. The tick strobe is high in the cycle the counter equals TICK_DIV-1. All state changes occur only on tick cycles.
- col_i is passed through a 2-flop synchroniser before any use.
- States:
  - LED_ON(row): col_oe=1, col_o=~row data, led_row_oe=1, led_row_o=1<<row. After ON_TICKS ticks → LED_BLANK.
  - LED_BLANK(row): col_oe=0, led_row_oe=0, col_o=all 1. After BLANK_TICKS ticks, row<LED_ROWS-1 → LED_ON(row+1); otherwise → SW_STROBE(0).
  - SW_STROBE(r): col_oe=0, sw_row_o=~(1<<r). On the final tick of the slot, sample[r]=~synchronised col_i. Then r<SW_ROWS-1 → SW_STROBE(r+1); otherwise → SW_GAP.
  - SW_GAP: sw_row_o all 1. After BLANK_TICKS ticks → LED_ON(0). Debounce update and frame_done fire on that transition.
- Switch rows are never strobed while col_oe=1. col_oe and led_row_oe are never high in SW states.
- led_data is read live each cycle during LED_ON. There is no frame buffer.
- Debounce, per bit, once per frame:
  - If the sample equals sw_state, the 4-bit counter clears.
  - Otherwise the counter increments. When the counter reaches DB_SAMPLES, sw_state toggles and the counter clears.
- sw_rise/sw_fall are computed from the old and new sw_state in the same cycle the update occurs.

## Timing
- Frame length is LED_ROWS*(ON_TICKS+BLANK_TICKS) + SW_ROWS*SW_TICKS + BLANK_TICKS ticks. Defaults give 277 ticks = 1,385,000 clk.
- Pad outputs are registered and change on the same clk edge as the state register.
- Switch latency: a stable change is reflected in sw_state after DB_SAMPLES frames, measured from the first frame that samples it.
- Reset values: col_o all 1, col_oe 0, led_row_o 0, led_row_oe 0, sw_row_o all 1, sw_state 0, sw_rise 0, sw_fall 0, frame_done 0. State is LED_ON(0); tick, slot and debounce counters are 0.
- After rst_n deasserts, the first tick occurs TICK_DIV cycles later, and LED row 0 outputs assert on the first clk edge.
- Reset mid-frame: all outputs return to reset values immediately, because reset is asynchronous. Partial samples are discarded.
- A bit bouncing between frames clears its counter, so no toggle occurs.

## Configuration
- MATRIX_SCANNER_EDGE_EN defined: sw_rise/sw_fall are generated as described above.
- Not defined: sw_rise/sw_fall are tied to 0, and their logic and previous-state storage are not built. sw_state behaviour is unchanged.

## Test plan
Bench parameters: COLS=4, LED_ROWS=2, SW_ROWS=2, TICK_DIV=4, ON_TICKS=2, BLANK_TICKS=1, SW_TICKS=1, DB_SAMPLES=2.
- Reset, then led_data=8'hA5 → row 0: led_row_o=2'b01, col_o=4'hA. Row 1: led_row_o=2'b10, col_o=4'h5. Each row is lit 8 clk, then blanked 4 clk.
- Frame length → frame_done pulses every 36 clk. sw_row_o sequence in SW states is 2'b10 then 2'b01. col_oe=0 throughout the SW states.
- col_i=4'b1110 held during row-0 strobes → sw_state[3:0]=4'b0001 after the 2nd frame_done, not the 1st. sw_rise[0] pulses once in the same cycle.
- Bounce: col_i alternates closed/open on successive frames → sw_state remains 0 and no sw_rise pulses.
- Release after closure held 2 frames → sw_fall[0] pulses once. With MATRIX_SCANNER_EDGE_EN undefined, sw_rise and sw_fall stay 0 throughout.
- rst_n pulsed low mid LED_ON(1) → outputs immediately return to reset values. The scan restarts at row 0, and sw_state=0.
